// File: rtl/median_pkg.sv
// Shared types and helpers for the streaming median filter.
// Window geometry and FSM state encoding live here.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam int WIN_MIN = 3;
  localparam int WIN_MAX = 9;

  function automatic int half(input int win);
    return (win - 1) / 2;
  endfunction

  function automatic bit win_ok(input int win);
    return (win >= WIN_MIN) && (win <= WIN_MAX) && (win % 2 == 1);
  endfunction

endpackage

// File: rtl/median_sort_net.sv
// Odd-even transposition sorter over N words of W bits.
// Only the middle element of the sorted result is exposed.
module median_sort_net #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   med
);

  logic [W-1:0] v [N];
  logic [W-1:0] t;

  always_comb begin
    t = '0;
    for (int i = 0; i < N; i++) v[i] = din[i*W +: W];
    // N alternating even/odd compare-exchange passes fully sort N words
    for (int s = 0; s < N; s++) begin
      for (int j = 0; j < N - 1; j++) begin
        if (((j % 2) == (s % 2)) && (v[j] > v[j+1])) begin
          t      = v[j];
          v[j]   = v[j+1];
          v[j+1] = t;
        end
      end
    end
    med = v[(N-1)/2];
  end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 1-D median filter with line framing and edge replication.
// Two-stage pipeline: window register (S1) then output register (S2).
module median_filter_stream
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              bypass,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int H  = half(WIN);
  localparam int CW = $clog2(H + 1);

  if (!win_ok(WIN)) begin : g_bad_win
    $error("median_filter_stream: WIN must be odd and within 3..9");
  end

  state_t            state;
  logic [DATA_W-1:0] w [WIN];
  logic [CW-1:0]     sc;
  logic [CW-1:0]     fc;
  logic              byp;
  logic              s1_emit;
  logic              s1_last;

  logic              adv;
  logic              acc;
  logic              flush_step;
  logic              shift;
  logic              emit_n;
  logic              last_n;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] med;
  logic [WIN*DATA_W-1:0] win_flat;

  assign adv        = !m_valid || m_ready;
  assign s_ready    = adv && (state != FLUSH) && rst_n;
  assign acc        = s_valid && s_ready;
  assign flush_step = adv && (state == FLUSH);
  assign shift      = flush_step || (acc && (state == RUN));
  // shift index after this shift is sc+1; the load was index 0
  assign emit_n     = shift && ((int'(sc) + 1) >= H);
  assign last_n     = flush_step && (fc == CW'(H - 1));
  assign din        = (state == FLUSH) ? w[WIN-1] : s_data;

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < WIN; i++) begin
      win_flat[i*DATA_W +: DATA_W] = w[i];
    end
  end

  median_sort_net #(
    .N (WIN),
    .W (DATA_W)
  ) u_sort (
    .din (win_flat),
    .med (med)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sc      <= '0;
      fc      <= '0;
      byp     <= 1'b0;
      s1_emit <= 1'b0;
      s1_last <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      for (int i = 0; i < WIN; i++) w[i] <= '0;
    end else if (adv) begin
      m_valid <= s1_emit;
      m_data  <= byp ? w[H] : med;
      m_last  <= s1_last;
      s1_emit <= emit_n;
      s1_last <= last_n;
      if (shift) begin
        for (int i = 0; i < WIN - 1; i++) w[i] <= w[i+1];
        w[WIN-1] <= din;
        sc <= (sc == CW'(H)) ? sc : sc + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (acc) begin
            for (int i = 0; i < WIN; i++) w[i] <= s_data;
            sc    <= '0;
            fc    <= '0;
            byp   <= bypass;
            state <= s_last ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (acc && s_last) begin
            fc    <= '0;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          fc <= fc + 1'b1;
          if (last_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
// Scoreboard bench for median_filter_stream at WIN = 3, 5 and 7.
// Expected outputs come from a sorted-window model over whole lines.
module tb_median_filter_stream;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int WIN = 3 + 2 * g;
    localparam int H   = (WIN - 1) / 2;

    logic          rst_n   = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data  = '0;
    logic          s_last  = 1'b0;
    logic          bypass  = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;

    exp_t sb[$];
    bit   done = 0;
    bit   bp_mode = 0;
    bit   gaps = 0;
    bit   discard = 0;
    int   stall_n = 0;
    bit   lat_arm = 0;
    int   lat_cnt = 0;
    int   lat_t = -1;
    int   negcnt = 0;
    bit   hold = 0;
    logic [DW-1:0] hold_d = '0;
    logic hold_l = 1'b0;
    bit   bub_on = 0;
    bit   bub_ok = 0;
    int   bub_n = 0;

    median_filter_stream #(
      .DATA_W (DW),
      .WIN    (WIN)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .bypass  (bypass),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL win%0d %s: got %0d, expected %0d", WIN, nm, act, exp);
      end
    endtask

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // median of the edge-replicated window around every sample of the line
    function automatic void push_expected(input int xs[$], input bit byp);
      int L;
      L = xs.size();
      for (int k = 0; k < L; k++) begin
        int   v;
        int   t[$];
        exp_t e;
        if (byp) begin
          v = xs[k];
        end else begin
          for (int j = -H; j <= H; j++) begin
            int idx;
            idx = k + j;
            if (idx < 0) idx = 0;
            if (idx > L - 1) idx = L - 1;
            t.push_back(xs[idx]);
          end
          t.sort();
          v = t[H];
        end
        e.d = DW'(v);
        e.l = (k == L - 1);
        sb.push_back(e);
      end
    endfunction

    task automatic do_reset();
      s_valid = 1'b0;
      s_last  = 1'b0;
      rst_n   = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("s_ready_in_reset", 32'(s_ready), 0);
      tick();
      rst_n   = 1'b1;
      discard = 0;
      @(negedge clk);
      chk("m_valid_after_reset", 32'(m_valid), 0);
      chk("m_last_after_reset", 32'(m_last), 0);
      chk("s_ready_after_reset", 32'(s_ready), 1);
      tick();
    endtask

    task automatic send_line(input int xs[$], input bit byp, input int rst_at,
                             input int stall_at, input bit lat);
      bit acc;
      int n;
      if (rst_at < 0) push_expected(xs, byp);
      else discard = 1;
      if (lat && xs.size() > H) begin
        lat_cnt = 0;
        lat_t   = -1;
        lat_arm = 1;
      end
      for (int i = 0; i < xs.size(); i++) begin
        if (i == rst_at) begin
          do_reset();
          return;
        end
        if (i == stall_at) stall_n = 5;
        s_valid = 1'b1;
        s_data  = DW'(xs[i]);
        s_last  = (i == xs.size() - 1);
        bypass  = (i == 0) ? byp : 1'($urandom_range(0, 1));
        n   = 0;
        acc = 0;
        while (!acc && n < 400) begin
          @(negedge clk);
          acc = s_ready;
          tick();
          n++;
        end
        if (!acc) begin
          checks++;
          errors++;
          $display("FAIL win%0d accept_timeout: got no s_ready, expected accept of sample %0d", WIN, i);
          s_valid = 1'b0;
          return;
        end
        if (gaps && i < xs.size() - 1) begin
          while ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            tick();
          end
        end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || m_valid) && n < 2000) begin
        tick();
        n++;
      end
      if (n >= 2000) begin
        checks++;
        errors++;
        $display("FAIL win%0d drain_timeout: got %0d pending, expected 0", WIN, sb.size());
      end
      repeat (2) tick();
    endtask

    initial begin
      forever begin
        tick();
        if (stall_n > 0) begin
          m_ready = 1'b0;
          stall_n--;
        end else if (bp_mode) begin
          m_ready = ($urandom_range(0, 2) != 0);
        end else begin
          m_ready = 1'b1;
        end
      end
    end

    // monitor: scoreboard pops, stall stability, latency and flush bubbles
    initial begin
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold    = 0;
          bub_on  = 0;
          lat_arm = 0;
        end else begin
          negcnt++;
          if (hold) begin
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data", 32'(m_data), 32'(hold_d));
            chk("hold_last", 32'(m_last), 32'(hold_l));
          end
          if (m_valid && !m_ready) chk("s_ready_stall", 32'(s_ready), 0);
          hold   = m_valid && !m_ready;
          hold_d = m_data;
          hold_l = m_last;
          if (lat_arm && s_valid && s_ready) begin
            lat_cnt++;
            if (lat_cnt == H + 1) lat_t = negcnt;
          end
          if (lat_arm && lat_t >= 0 && m_valid) begin
            chk("latency", 32'(negcnt - lat_t), 2);
            lat_arm = 0;
          end
          if (bub_on) begin
            if (!m_ready) bub_ok = 0;
            if (!s_ready) begin
              bub_n++;
            end else begin
              if (bub_ok && !bp_mode) chk("flush_bubbles", 32'(bub_n), H);
              bub_on = 0;
            end
          end
          if (s_valid && s_ready && s_last) begin
            bub_on = 1;
            bub_ok = m_ready;
            bub_n  = 0;
          end
          if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
              if (!discard) begin
                checks++;
                errors++;
                $display("FAIL win%0d unexpected_output: got %0d, expected none", WIN, m_data);
              end
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("data", 32'(m_data), 32'(e.d));
              chk("last", 32'(m_last), 32'(e.l));
            end
          end
        end
      end
    end

    initial begin
      int q[$];
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_last", 32'(m_last), 0);
      tick();
      rst_n = 1'b1;
      tick();

      q = {5, 1, 9, 3};
      send_line(q, 0, -1, -1, 1);
      drain();
      q = {7};
      send_line(q, 0, -1, -1, 0);
      q = {2, 8};
      send_line(q, 0, -1, -1, 0);
      drain();
      q = {0, 0, 255, 0, 0, 0};
      send_line(q, 0, -1, -1, 1);
      drain();
      send_line(q, 1, -1, -1, 1);
      drain();

      q.delete();
      for (int i = 0; i < 16; i++) q.push_back(i);
      send_line(q, 0, -1, 8, 0);
      drain();

      for (int n = 0; n < 2; n++) begin
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(int'($urandom_range(0, 255)));
        send_line(q, 0, -1, -1, 0);
      end
      drain();

      q = {1, 2, 3, 4, 5, 6, 7, 8};
      send_line(q, 0, 5, -1, 0);
      q = {4, 6};
      send_line(q, 0, -1, -1, 0);
      drain();

      bp_mode = 1;
      gaps    = 1;
      for (int n = 0; n < 30; n++) begin
        int len;
        bit narrow;
        len    = int'($urandom_range(1, 12));
        narrow = 1'($urandom_range(0, 1));
        q.delete();
        for (int i = 0; i < len; i++) begin
          q.push_back(narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)));
        end
        send_line(q, 1'($urandom_range(0, 1)), -1, -1, 0);
      end
      drain();
      done = 1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && t < 80000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 80000) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got %0d cycles, expected all lanes done", t);
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
